// File: rtl/role_pkg.sv
// Shared types and defaults for the stream reduction role.
package role_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CH     = 4;
    localparam int DEF_SUM_W  = 48;
    localparam int DEF_CNT_W  = 16;

    // LSB position of lane 'lane' in a bus made of 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/role_sum_lane.sv
// One lane accumulator: adds a zero-extended input lane, reports the carry out.
module role_sum_lane #(
    parameter int DATA_W = 32,
    parameter int SUM_W  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] din,
    output logic [SUM_W-1:0]  sum_nxt,
    output logic              carry
);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W:0]   sum_ext;

    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, din};
        sum_nxt = sum_ext[SUM_W-1:0];
        carry   = add_en & sum_ext[SUM_W];
        // Clear wins so the closing beat of a packet starts the next one at zero.
        acc_d   = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = sum_ext[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/role_stream_sum.sv
// Multi-lane AXI4-Stream reduction role: one result beat (lane sums + beat count)
// per tlast-framed input packet, for a commanded number of packets.
module role_stream_sum
    import role_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH     = DEF_CH,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      pkt_num,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf,
    input  logic [CH*DATA_W-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [CH*SUM_W-1:0]   m_axis_tdata,
    output logic [CNT_W-1:0]      m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [1:0]            dbg_state
);

    localparam logic [CNT_W-1:0] BEAT_MAX = '1;

    // Valid/ready: a beat moves on a clock edge where valid and ready are both
    // high; the source holds data/last stable while valid is high and ready low.
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic [CNT_W-1:0]     beats_q, beats_d, beats_inc;
    logic [CNT_W-1:0]     res_user_q, res_user_d;
    logic [CH*SUM_W-1:0]  res_data_q, res_data_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                 s_tready_q, s_tready_d, m_tvalid_q, m_tvalid_d;
    logic                 m_tlast_q, m_tlast_d;
    logic [CH*SUM_W-1:0]  lane_sum_nxt;
    logic [CH-1:0]        lane_carry;
    logic                 in_fire, out_fire, start_go, lane_clr;

    assign in_fire  = s_tready_q & s_axis_tvalid;
    assign out_fire = m_tvalid_q & m_axis_tready;
    assign start_go = (state_q == IDLE) & start & (pkt_num != '0);
    assign lane_clr = start_go | (in_fire & s_axis_tlast);

    for (genvar i = 0; i < CH; i++) begin : g_lane
        role_sum_lane #(
            .DATA_W (DATA_W),
            .SUM_W  (SUM_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (lane_clr),
            .add_en  (in_fire),
            .din     (s_axis_tdata[lane_lsb(i, DATA_W) +: DATA_W]),
            .sum_nxt (lane_sum_nxt[lane_lsb(i, SUM_W) +: SUM_W]),
            .carry   (lane_carry[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        res_user_d  = res_user_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        m_tlast_d   = m_tlast_q;
        done_d      = 1'b0;
        beats_inc   = (beats_q == BEAT_MAX) ? BEAT_MAX : beats_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (pkt_num != '0) begin
                        remaining_d = pkt_num;
                        beats_d     = '0;
                        err_d       = 1'b0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_fire) begin
                    beats_d = beats_inc;
                    if ((lane_carry != '0) || (beats_q == BEAT_MAX)) begin
                        err_d = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        res_data_d  = lane_sum_nxt;
                        res_user_d  = beats_inc;
                        remaining_d = remaining_q - CNT_W'(1);
                        beats_d     = '0;
                        m_tlast_d   = (remaining_q == CNT_W'(1));
                        state_d     = OUT;
                    end
                end
            end
            OUT: begin
                if (out_fire) begin
                    if (remaining_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != OUT) begin
            m_tlast_d = 1'b0;
        end
        busy_d     = (state_d != IDLE);
        s_tready_d = (state_d == RUN);
        m_tvalid_d = (state_d == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            beats_q     <= '0;
            res_user_q  <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            res_user_q  <= res_user_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_ovf       = err_q;
    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tdata  = res_data_q;
    assign m_axis_tuser  = res_user_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_role_stream_sum.sv
// Directed bench for role_stream_sum with 33-bit lane sums so wrap-around is reachable.
module tb_role_stream_sum;

    localparam int DATA_W = 32;
    localparam int CH     = 4;
    localparam int SUM_W  = 33;
    localparam int CNT_W  = 16;
    localparam int DW     = CH * DATA_W;
    localparam int RW     = CH * SUM_W;

    logic             clk, rst_n, start, busy, done, err_ovf;
    logic [CNT_W-1:0] pkt_num;
    logic [DW-1:0]    s_axis_tdata;
    logic             s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [RW-1:0]    m_axis_tdata;
    logic [CNT_W-1:0] m_axis_tuser;
    logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [1:0]       dbg_state;

    role_stream_sum #(
        .DATA_W (DATA_W),
        .CH     (CH),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pkt_num       (pkt_num),
        .busy          (busy),
        .done          (done),
        .err_ovf       (err_ovf),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [RW-1:0]    exp_q[$];
    logic [CNT_W-1:0] exp_user_q[$];

    task automatic check_val(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_beat(input logic [31:0] d0, input logic [31:0] d1,
                                              input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [RW-1:0] mk_res(input logic [SUM_W-1:0] r0, input logic [SUM_W-1:0] r1,
                                             input logic [SUM_W-1:0] r2, input logic [SUM_W-1:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic expect_result(input logic [RW-1:0] d, input logic [CNT_W-1:0] u);
        exp_q.push_back(d);
        exp_user_q.push_back(u);
    endtask

    // driver tasks
    task automatic do_start(input logic [CNT_W-1:0] n);
        start   = 1'b1;
        pkt_num = n;
        step();
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int t;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        t = 0;
        while (!s_axis_tready && t < 50) begin
            step();
            t++;
        end
        if (t == 50) check_val("beat_timeout", RW'(s_axis_tready), RW'(1));
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // scoreboard: pop the expected result, hold off ready for 'stall' cycles
    task automatic get_result(input int stall, input logic exp_last);
        logic [RW-1:0]    ed;
        logic [CNT_W-1:0] eu;
        int t;
        ed = exp_q.pop_front();
        eu = exp_user_q.pop_front();
        t = 0;
        while (!m_axis_tvalid && t < 100) begin
            step();
            t++;
        end
        check_val("res_valid", RW'(m_axis_tvalid), RW'(1));
        check_val("res_data", m_axis_tdata, ed);
        check_val("res_user", RW'(m_axis_tuser), RW'(eu));
        check_val("res_last", RW'(m_axis_tlast), RW'(exp_last));
        check_val("res_s_ready", RW'(s_axis_tready), RW'(0));
        for (int c = 0; c < stall; c++) begin
            step();
            check_val("stall_valid", RW'(m_axis_tvalid), RW'(1));
            check_val("stall_data", m_axis_tdata, ed);
            check_val("stall_user", RW'(m_axis_tuser), RW'(eu));
            check_val("stall_last", RW'(m_axis_tlast), RW'(exp_last));
        end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, RW'(busy), RW'(0));
        check_val({tag, "_done"}, RW'(done), RW'(0));
        check_val({tag, "_err"}, RW'(err_ovf), RW'(0));
        check_val({tag, "_s_ready"}, RW'(s_axis_tready), RW'(0));
        check_val({tag, "_m_valid"}, RW'(m_axis_tvalid), RW'(0));
        check_val({tag, "_m_last"}, RW'(m_axis_tlast), RW'(0));
        check_val({tag, "_m_data"}, m_axis_tdata, RW'(0));
        check_val({tag, "_m_user"}, RW'(m_axis_tuser), RW'(0));
        check_val({tag, "_state"}, RW'(dbg_state), RW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        pkt_num       = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // basic: 3 beats of 1,2,3 in every lane
        do_start(16'd1);
        check_val("basic_busy", RW'(busy), RW'(1));
        check_val("basic_s_ready", RW'(s_axis_tready), RW'(1));
        expect_result(mk_res(33'd6, 33'd6, 33'd6, 33'd6), 16'd3);
        send_beat(mk_beat(1, 1, 1, 1), 1'b0);
        send_beat(mk_beat(2, 2, 2, 2), 1'b0);
        send_beat(mk_beat(3, 3, 3, 3), 1'b1);
        check_val("basic_valid_next", RW'(m_axis_tvalid), RW'(1));
        get_result(0, 1'b1);
        check_val("basic_done", RW'(done), RW'(1));
        check_val("basic_busy_done", RW'(busy), RW'(1));
        step();
        check_val("basic_done_clr", RW'(done), RW'(0));
        check_val("basic_idle", RW'(busy), RW'(0));
        check_val("basic_err", RW'(err_ovf), RW'(0));

        // multi-packet 1/4/2 beats with 5-cycle backpressure on each result
        do_start(16'd3);
        expect_result(mk_res(33'd5, 33'd5, 33'd5, 33'd5), 16'd1);
        send_beat(mk_beat(5, 5, 5, 5), 1'b1);
        get_result(5, 1'b0);
        expect_result(mk_res(33'd4, 33'd8, 33'd12, 33'd16), 16'd4);
        for (int b = 0; b < 4; b++) send_beat(mk_beat(1, 2, 3, 4), b == 3);
        get_result(5, 1'b0);
        expect_result(mk_res(33'h120, 33'h120, 33'h120, 33'h120), 16'd2);
        send_beat(mk_beat(32'h100, 32'h100, 32'h100, 32'h100), 1'b0);
        send_beat(mk_beat(32'h20, 32'h20, 32'h20, 32'h20), 1'b1);
        get_result(5, 1'b1);
        check_val("multi_done", RW'(done), RW'(1));
        step();
        check_val("multi_idle", RW'(busy), RW'(0));

        // overflow: 3 x 0xFFFF_FFFF in lane 0 wraps mod 2^33
        do_start(16'd1);
        expect_result(mk_res(33'h0_FFFF_FFFD, 33'd0, 33'd0, 33'd0), 16'd3);
        send_beat(mk_beat(32'hFFFF_FFFF, 0, 0, 0), 1'b0);
        send_beat(mk_beat(32'hFFFF_FFFF, 0, 0, 0), 1'b0);
        check_val("ovf_not_yet", RW'(err_ovf), RW'(0));
        send_beat(mk_beat(32'hFFFF_FFFF, 0, 0, 0), 1'b1);
        check_val("ovf_set", RW'(err_ovf), RW'(1));
        get_result(0, 1'b1);
        step();
        check_val("ovf_sticky_idle", RW'(err_ovf), RW'(1));
        do_start(16'd1);
        check_val("ovf_clr_on_start", RW'(err_ovf), RW'(0));
        expect_result(mk_res(33'd1, 33'd1, 33'd1, 33'd1), 16'd1);
        send_beat(mk_beat(1, 1, 1, 1), 1'b1);
        get_result(0, 1'b1);
        step();

        // zero-packet command, then a start ignored mid-run
        do_start(16'd0);
        check_val("zero_done", RW'(done), RW'(1));
        check_val("zero_busy", RW'(busy), RW'(0));
        step();
        check_val("zero_done_clr", RW'(done), RW'(0));
        check_val("zero_busy2", RW'(busy), RW'(0));
        do_start(16'd2);
        expect_result(mk_res(33'd7, 33'd7, 33'd7, 33'd7), 16'd2);
        expect_result(mk_res(33'd1, 33'd2, 33'd3, 33'd4), 16'd1);
        start   = 1'b1;
        pkt_num = 16'd7;
        send_beat(mk_beat(3, 3, 3, 3), 1'b0);
        start   = 1'b0;
        pkt_num = 16'd0;
        send_beat(mk_beat(4, 4, 4, 4), 1'b1);
        get_result(0, 1'b0);
        send_beat(mk_beat(1, 2, 3, 4), 1'b1);
        get_result(0, 1'b1);
        check_val("ign_done", RW'(done), RW'(1));
        step();
        step();
        step();
        check_val("ign_idle", RW'(busy), RW'(0));
        check_val("ign_no_extra", RW'(m_axis_tvalid), RW'(0));

        // reset in the middle of a 5-beat packet
        do_start(16'd1);
        send_beat(mk_beat(9, 9, 9, 9), 1'b0);
        send_beat(mk_beat(9, 9, 9, 9), 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step();
        step();
        rst_n = 1'b1;
        step();
        do_start(16'd1);
        expect_result(mk_res(33'd14, 33'd14, 33'd14, 33'd14), 16'd2);
        send_beat(mk_beat(7, 7, 7, 7), 1'b0);
        send_beat(mk_beat(7, 7, 7, 7), 1'b1);
        get_result(0, 1'b1);
        step();

        // back-to-back single-beat packets with continuous valid and ready
        m_axis_tready = 1'b1;
        s_axis_tlast  = 1'b1;
        do_start(16'd4);
        for (int j = 0; j < 8; j++) begin
            s_axis_tdata  = mk_beat(j / 2 + 1, j / 2 + 1, j / 2 + 1, j / 2 + 1);
            s_axis_tvalid = (j < 7);
            check_val("b2b_s_ready", RW'(s_axis_tready), RW'(j % 2 == 0));
            check_val("b2b_m_valid", RW'(m_axis_tvalid), RW'(j % 2 == 1));
            if (j % 2 == 1) begin
                check_val("b2b_data", m_axis_tdata,
                          mk_res(SUM_W'(j / 2 + 1), SUM_W'(j / 2 + 1), SUM_W'(j / 2 + 1), SUM_W'(j / 2 + 1)));
                check_val("b2b_user", RW'(m_axis_tuser), RW'(1));
                check_val("b2b_last", RW'(m_axis_tlast), RW'(j == 7));
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        check_val("b2b_done", RW'(done), RW'(1));
        step();
        check_val("b2b_idle", RW'(busy), RW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/role_stream_sum.md
# role_stream_sum

Parametrised successor to the empty acceleration-core role: a multi-lane AXI4-Stream reduction engine that sits in the role slot between the shell's host-to-card and card-to-host streams. Under a start/busy/done command handshake it consumes a programmed number of tlast-framed packets. For each packet it emits one result beat carrying the per-lane unsigned sums and the beat count. A sticky overflow flag reports wrap-around.

## Interface
Parameters:
- DATA_W, 32, width of one input lane
- CH, 4, number of lanes per beat (≥1)
- SUM_W, 48, width of one lane accumulator (≥ DATA_W)
- CNT_W, 16, width of packet-number and beat-count fields

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse, sampled only in IDLE
- pkt_num  in  CNT_W  packets to process, sampled with start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- err_ovf  out  1  sticky overflow flag
- s_axis_tdata  in  CH*DATA_W  lane i = bits [i*DATA_W +: DATA_W]
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  last beat of a packet
- m_axis_tdata  out  CH*SUM_W  lane i sum = bits [i*SUM_W +: SUM_W]
- m_axis_tuser  out  CNT_W  beat count of the packet
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  marks the result of the final packet

## Operation
- FSM states: IDLE, RUN, OUT, DONE.
- IDLE:
  - s_axis_tready = 0.
  - start with pkt_num ≠ 0: load remaining = pkt_num, clear accumulators, beat counter and err_ovf, then go to RUN.
  - start with pkt_num = 0: pulse done on the next cycle and stay in IDLE. busy never rises.
- RUN:
  - s_axis_tready = 1.
  - Each accepted beat: acc[i] += zero-extended lane i, modulo 2^SUM_W; beats += 1.
  - A carry out of any acc[i] sets err_ovf.
  - beats saturates at 2^CNT_W−1; attempting to exceed that sets err_ovf.
  - Beat with tlast: load the result register with the updated acc[] and beats, including the tlast beat itself; decrement remaining; clear acc/beats; go to OUT.
- OUT:
  - s_axis_tready = 0, m_axis_tvalid = 1.
  - m_axis_tlast = (remaining == 0).
  - m_axis_tdata, m_axis_tuser and m_axis_tlast are held stable while tvalid && !tready.
  - On handshake: go to DONE if remaining == 0, else to RUN.
- DONE: done = 1 for one cycle, then go to IDLE.
- busy = (state ≠ IDLE).
- start outside IDLE is ignored, and pkt_num changes while busy have no effect.
- err_ovf is cleared only by reset or by an accepted start.
- Reset values: state IDLE; busy, done, err_ovf, s_axis_tready, m_axis_tvalid, m_axis_tlast all 0; m_axis_tdata, m_axis_tuser and accumulators all 0.
- Reset asserted mid-packet discards all partial state. There is no recovery of in-flight results.

## Timing
- All outputs are registered. s_axis_tready is a registered function of state.
- tlast beat accepted in cycle N → m_axis_tvalid high in cycle N+1.
- Last result handshake in cycle M → done pulse in M+1; IDLE, busy = 0 from M+2.
- Throughput: one input beat per cycle within a packet, plus at least one non-accepting cycle per packet while in OUT.
- Single-beat packets are legal: tlast on the first beat gives beats = 1.
- start accepted in cycle K → busy and s_axis_tready high from K+1.

## Structure
- Package role_pkg holds:
  - the state enum typedef (IDLE, RUN, OUT, DONE);
  - default localparams for DATA_W, CH, SUM_W, CNT_W;
  - a lane-slice helper function.
- Sub-module role_sum_lane is generated CH times. It contains one SUM_W accumulator with add-enable, synchronous clear and a carry-out output.
- The top level holds the FSM, the remaining and beat counters, the result register and the err_ovf OR-reduction.

## Test plan
- Basic (CH=4, DATA_W=32): pkt_num=1, 3 beats with every lane {1,2,3}, tlast on beat 3 → one result with every lane = 6, tuser = 3, tlast = 1. done follows one cycle after the handshake; err_ovf = 0.
- Multi-packet with backpressure: pkt_num=3, packet lengths 1/4/2, m_axis_tready held low for 5 cycles on each result → three results in order with tuser = 1/4/2. Outputs are stable while stalled; tlast only on the third result.
- Overflow (SUM_W=33): two beats of 0xFFFF_FFFF in lane 0, then a third beat → lane-0 result wraps modulo 2^33 and err_ovf = 1. err_ovf stays 1 after done and clears on the next start.
- Zero and ignored commands: start with pkt_num = 0 → done pulse, busy never high. Then start with pkt_num = 2, plus a second start pulse mid-run → the second start is ignored and exactly 2 results are produced.
- Reset mid-packet: assert rst_n low after 2 beats of a 5-beat packet → all outputs 0 immediately. A fresh run afterwards, 2 beats of lane value 7 with pkt_num = 1, gives lane sums 14 and tuser = 2, with no residue from the aborted packet.
- Back-to-back timing: continuous tvalid with 1-beat packets and pkt_num = 4 → tready follows the pattern 1,0,1,0… and each result appears exactly one cycle after its tlast beat.
